// File: rtl/ace_snoop_responder_pkg.sv
// Shared types for the ACE snoop responder: snoop/response encodings, update ops, FSM states
// and the snoop-to-response decision function.
package ace_snoop_responder_pkg;

  typedef enum logic [3:0] {
    SnpReadOnce           = 4'b0000,
    SnpReadShared         = 4'b0001,
    SnpReadClean          = 4'b0010,
    SnpReadNotSharedDirty = 4'b0011,
    SnpReadUnique         = 4'b0111,
    SnpCleanShared        = 4'b1000,
    SnpCleanInvalid       = 4'b1001,
    SnpMakeInvalid        = 4'b1101,
    SnpDvmComplete        = 4'b1110,
    SnpDvmMessage         = 4'b1111
  } acsnoop_t;

  // Bit order matches CRRESP[4:0]
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  typedef enum logic [1:0] {
    UpdNone       = 2'b00,
    UpdInvalidate = 2'b01,
    UpdMakeClean  = 2'b10,
    UpdMakeShared = 2'b11
  } upd_op_t;

  typedef struct packed {
    crresp_t resp;
    upd_op_t op;
  } snoop_result_t;

  typedef enum logic [2:0] {
    StIdle, StLookup, StWait, StUpdate, StResp, StData
  } state_e;

  function automatic snoop_result_t snoop_resp(input acsnoop_t snoop, input logic hit,
                                               input logic dirty, input logic shared);
    snoop_result_t r;
    r = '0;
    if (hit) begin
      r.resp.was_unique = ~shared;
      case (snoop)
        SnpReadOnce: begin
          r.resp.data_transfer = 1'b1;
          r.resp.is_shared     = 1'b1;
        end
        SnpReadShared, SnpReadNotSharedDirty: begin
          r.resp.data_transfer = 1'b1;
          r.resp.is_shared     = 1'b1;
          r.resp.pass_dirty    = dirty;
          r.op                 = UpdMakeShared;
        end
        // Line keeps its dirty state, so ownership of the dirt is not passed
        SnpReadClean: begin
          r.resp.data_transfer = 1'b1;
          r.resp.is_shared     = 1'b1;
          r.op                 = UpdMakeShared;
        end
        SnpReadUnique, SnpCleanInvalid: begin
          r.resp.data_transfer = dirty | (snoop == SnpReadUnique);
          r.resp.pass_dirty    = dirty;
          r.op                 = UpdInvalidate;
        end
        SnpCleanShared: begin
          r.resp.data_transfer = dirty;
          r.resp.pass_dirty    = dirty;
          r.resp.is_shared     = 1'b1;
          r.op                 = dirty ? UpdMakeClean : UpdNone;
        end
        SnpMakeInvalid: begin
          r.op = UpdInvalidate;
        end
        default: r = '0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ace_line_serializer.sv
// Holds one cache line and streams it out LSB-first as CD beats under valid/ready.
module ace_line_serializer #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LineWidth = 512
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [LineWidth-1:0] line_i,
  input  logic                 en_i,
  output logic                 cd_valid_o,
  input  logic                 cd_ready_i,
  output logic [DataWidth-1:0] cd_data_o,
  output logic                 cd_last_o,
  output logic                 done_o
);

  localparam int unsigned NumBeats = LineWidth / DataWidth;
  localparam int unsigned CntWidth = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumBeats - 1);

  logic [NumBeats-1:0][DataWidth-1:0] line_q;
  logic [CntWidth-1:0]                cnt_q;
  logic                               beat_done;

  assign cd_valid_o = en_i;
  assign cd_data_o  = line_q[cnt_q];
  assign cd_last_o  = en_i && (cnt_q == LastCnt);
  assign beat_done  = cd_valid_o && cd_ready_i;
  assign done_o     = beat_done && cd_last_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (load_i) line_q <= line_i;
      if (beat_done) cnt_q <= cd_last_o ? '0 : cnt_q + CntWidth'(1);
    end
  end

endmodule

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: one outstanding snoop, cache lookup, optional state update,
// CR response and optional full-line CD transfer.
module ace_snoop_responder
  import ace_snoop_responder_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LineWidth = 512
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ac_valid_i,
  output logic                 ac_ready_o,
  input  logic [AddrWidth-1:0] ac_addr_i,
  input  acsnoop_t             ac_snoop_i,
  input  logic [2:0]           ac_prot_i,
  output logic                 cr_valid_o,
  input  logic                 cr_ready_i,
  output crresp_t              cr_resp_o,
  output logic                 cd_valid_o,
  input  logic                 cd_ready_i,
  output logic [DataWidth-1:0] cd_data_o,
  output logic                 cd_last_o,
  output logic                 lkp_req_o,
  input  logic                 lkp_gnt_i,
  output logic [AddrWidth-1:0] lkp_addr_o,
  input  logic                 lkp_valid_i,
  input  logic                 lkp_hit_i,
  input  logic                 lkp_dirty_i,
  input  logic                 lkp_shared_i,
  input  logic [LineWidth-1:0] lkp_line_i,
  output logic                 upd_valid_o,
  input  logic                 upd_ready_i,
  output upd_op_t              upd_op_o
);

  localparam logic [AddrWidth-1:0] LineMask = AddrWidth'(LineWidth / 8 - 1);

  if (LineWidth % DataWidth != 0) begin : gen_width_check
    $error("LineWidth must be a multiple of DataWidth");
  end

  state_e         state_q, state_d;
  logic [AddrWidth-1:0] addr_q;
  acsnoop_t       snoop_q;
  logic [2:0]     prot_q;
  crresp_t        resp_q;
  upd_op_t        op_q;
  snoop_result_t  lkp_res;
  logic           ac_capture, lkp_capture, cd_en, cd_done;

  assign lkp_res    = snoop_resp(snoop_q, lkp_hit_i, lkp_dirty_i, lkp_shared_i);
  assign lkp_addr_o = addr_q & ~LineMask;

  always_comb begin
    state_d     = state_q;
    ac_ready_o  = 1'b0;
    lkp_req_o   = 1'b0;
    upd_valid_o = 1'b0;
    upd_op_o    = UpdNone;
    cr_valid_o  = 1'b0;
    cr_resp_o   = '0;
    cd_en       = 1'b0;
    ac_capture  = 1'b0;
    lkp_capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        ac_ready_o = 1'b1;
        if (ac_valid_i) begin
          ac_capture = 1'b1;
          // DVM snoops never touch the cache
          state_d = (ac_snoop_i inside {SnpDvmComplete, SnpDvmMessage}) ? StResp : StLookup;
        end
      end
      StLookup: begin
        lkp_req_o = 1'b1;
        if (lkp_gnt_i) state_d = StWait;
      end
      StWait: begin
        if (lkp_valid_i) begin
          lkp_capture = 1'b1;
          state_d     = (lkp_res.op != UpdNone) ? StUpdate : StResp;
        end
      end
      StUpdate: begin
        upd_valid_o = 1'b1;
        upd_op_o    = op_q;
        if (upd_ready_i) state_d = StResp;
      end
      StResp: begin
        cr_valid_o = 1'b1;
        cr_resp_o  = resp_q;
        if (cr_ready_i) state_d = resp_q.data_transfer ? StData : StIdle;
      end
      StData: begin
        cd_en = 1'b1;
        if (cd_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      snoop_q <= SnpReadOnce;
      prot_q  <= '0;
      resp_q  <= '0;
      op_q    <= UpdNone;
    end else begin
      state_q <= state_d;
      if (ac_capture) begin
        addr_q  <= ac_addr_i;
        snoop_q <= ac_snoop_i;
        prot_q  <= ac_prot_i;
        resp_q  <= '0;
        op_q    <= UpdNone;
      end
      if (lkp_capture) begin
        resp_q <= lkp_res.resp;
        op_q   <= lkp_res.op;
      end
    end
  end

  ace_line_serializer #(
    .DataWidth(DataWidth),
    .LineWidth(LineWidth)
  ) u_serializer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (lkp_capture),
    .line_i    (lkp_line_i),
    .en_i      (cd_en),
    .cd_valid_o(cd_valid_o),
    .cd_ready_i(cd_ready_i),
    .cd_data_o (cd_data_o),
    .cd_last_o (cd_last_o),
    .done_o    (cd_done)
  );

  snoop_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ac_valid_i |-> !$isunknown({ac_snoop_i, ac_prot_i}));
  prot_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != StIdle) |-> !$isunknown(prot_q));
  cr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cr_valid_o && !cr_ready_i |=> cr_valid_o && $stable(cr_resp_o));
  cd_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cd_valid_o && !cd_ready_i |=> cd_valid_o && $stable(cd_data_o) && $stable(cd_last_o));
  upd_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    upd_valid_o && !upd_ready_i |=> upd_valid_o && $stable(upd_op_o));
  lkp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lkp_req_o && !lkp_gnt_i |=> lkp_req_o && $stable(lkp_addr_o));

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder: hand-computed responses, update ops and CD beats.
module tb_ace_snoop_responder;
  import ace_snoop_responder_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ac_valid, ac_ready;
  logic [63:0]   ac_addr;
  acsnoop_t      ac_snoop;
  logic [2:0]    ac_prot;
  logic          cr_valid, cr_ready;
  crresp_t       cr_resp;
  logic          cd_valid, cd_ready, cd_last;
  logic [63:0]   cd_data;
  logic          lkp_req, lkp_gnt, lkp_valid, lkp_hit, lkp_dirty, lkp_shared;
  logic [63:0]   lkp_addr;
  logic [511:0]  lkp_line;
  logic          upd_valid, upd_ready;
  upd_op_t       upd_op;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ace_snoop_responder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ac_valid_i  (ac_valid),
    .ac_ready_o  (ac_ready),
    .ac_addr_i   (ac_addr),
    .ac_snoop_i  (ac_snoop),
    .ac_prot_i   (ac_prot),
    .cr_valid_o  (cr_valid),
    .cr_ready_i  (cr_ready),
    .cr_resp_o   (cr_resp),
    .cd_valid_o  (cd_valid),
    .cd_ready_i  (cd_ready),
    .cd_data_o   (cd_data),
    .cd_last_o   (cd_last),
    .lkp_req_o   (lkp_req),
    .lkp_gnt_i   (lkp_gnt),
    .lkp_addr_o  (lkp_addr),
    .lkp_valid_i (lkp_valid),
    .lkp_hit_i   (lkp_hit),
    .lkp_dirty_i (lkp_dirty),
    .lkp_shared_i(lkp_shared),
    .lkp_line_i  (lkp_line),
    .upd_valid_o (upd_valid),
    .upd_ready_i (upd_ready),
    .upd_op_o    (upd_op)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_val(input logic [31:0] seed, input int i);
    return {seed, 32'(i) * 32'h0101_0101};
  endfunction

  function automatic logic [511:0] make_line(input logic [31:0] seed);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = beat_val(seed, i);
    return l;
  endfunction

  // Drives one AC beat; returns at the negedge after the handshake edge.
  task automatic send_ac(input acsnoop_t s, input logic [63:0] a);
    ac_valid = 1'b1;
    ac_snoop = s;
    ac_addr  = a;
    ac_prot  = 3'b010;
    @(negedge clk);
    ac_valid = 1'b0;
  endtask

  // Called in LOOKUP; returns at the negedge after the lookup response edge.
  task automatic lookup(input logic [63:0] exp_addr, input logic hit, input logic dirty,
                        input logic shared, input logic [31:0] seed);
    check("lkp_req", lkp_req, 1'b1);
    check("lkp_addr", lkp_addr, exp_addr);
    @(negedge clk);
    check("lkp_req_drop", lkp_req, 1'b0);
    lkp_valid  = 1'b1;
    lkp_hit    = hit;
    lkp_dirty  = dirty;
    lkp_shared = shared;
    lkp_line   = make_line(seed);
    @(negedge clk);
    lkp_valid  = 1'b0;
  endtask

  task automatic burst(input logic [31:0] seed);
    for (int i = 0; i < 8; i++) begin
      check("cd_valid", cd_valid, 1'b1);
      check("cd_data", cd_data, beat_val(seed, i));
      check("cd_last", cd_last, i == 7);
      @(negedge clk);
    end
    check("cd_valid_end", cd_valid, 1'b0);
    check("ac_ready_end", ac_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    ac_valid = 0; ac_addr = '0; ac_snoop = SnpReadOnce; ac_prot = '0;
    cr_ready = 0; cd_ready = 0; lkp_gnt = 0; lkp_valid = 0;
    lkp_hit = 0; lkp_dirty = 0; lkp_shared = 0; lkp_line = '0; upd_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_ac_ready", ac_ready, 1'b1);
    check("rst_cr_valid", cr_valid, 1'b0);
    check("rst_cd_valid", cd_valid, 1'b0);
    check("rst_lkp_req", lkp_req, 1'b0);
    check("rst_upd_valid", upd_valid, 1'b0);
    check("rst_cr_resp", cr_resp, 5'h00);
    check("rst_upd_op", upd_op, 2'b00);
    rst_n = 1'b1;
    lkp_gnt = 1; upd_ready = 1; cr_ready = 1; cd_ready = 1;
    @(negedge clk);

    // ReadShared, hit dirty unique
    send_ac(SnpReadShared, 64'h1234_5678_9ABC_DEF5);
    lookup(64'h1234_5678_9ABC_DEC0, 1'b1, 1'b1, 1'b0, 32'hA0A0_0001);
    check("rs_upd_valid", upd_valid, 1'b1);
    check("rs_upd_op", upd_op, 2'b11);
    check("rs_cr_early", cr_valid, 1'b0);
    @(negedge clk);
    check("rs_cr_valid", cr_valid, 1'b1);
    check("rs_cr_resp", cr_resp, 5'h1D);
    @(negedge clk);
    burst(32'hA0A0_0001);

    // MakeInvalid, hit clean shared
    send_ac(SnpMakeInvalid, 64'h0000_0000_0000_0047);
    lookup(64'h0000_0000_0000_0040, 1'b1, 1'b0, 1'b1, 32'hB0B0_0002);
    check("mi_upd_op", upd_op, 2'b01);
    @(negedge clk);
    check("mi_cr_valid", cr_valid, 1'b1);
    check("mi_cr_resp", cr_resp, 5'h00);
    @(negedge clk);
    check("mi_ac_ready", ac_ready, 1'b1);
    check("mi_no_cd", cd_valid, 1'b0);

    // ReadUnique miss
    send_ac(SnpReadUnique, 64'hFFFF_0000_1111_2280);
    lookup(64'hFFFF_0000_1111_2280, 1'b0, 1'b0, 1'b0, 32'hC0C0_0003);
    check("ru_cr_valid", cr_valid, 1'b1);
    check("ru_no_upd", upd_valid, 1'b0);
    check("ru_cr_resp", cr_resp, 5'h00);
    @(negedge clk);
    check("ru_no_cd", cd_valid, 1'b0);
    check("ru_ac_ready", ac_ready, 1'b1);

    // DVMMessage
    send_ac(SnpDvmMessage, 64'h0000_0000_0000_1000);
    check("dvm_no_lkp", lkp_req, 1'b0);
    check("dvm_cr_valid", cr_valid, 1'b1);
    check("dvm_cr_resp", cr_resp, 5'h00);
    @(negedge clk);
    check("dvm_ac_ready", ac_ready, 1'b1);

    // CleanShared, hit dirty shared, stalled CR and toggling CD ready
    cr_ready = 0;
    send_ac(SnpCleanShared, 64'h0000_0000_0000_2000);
    lookup(64'h0000_0000_0000_2000, 1'b1, 1'b1, 1'b1, 32'hD0D0_0005);
    check("cs_upd_op", upd_op, 2'b10);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      check("cs_cr_valid", cr_valid, 1'b1);
      check("cs_cr_resp", cr_resp, 5'h0D);
      if (k == 5) cr_ready = 1;
      @(negedge clk);
    end
    cnt = 0;
    for (int cyc = 0; cyc < 40 && cnt < 8; cyc++) begin
      cd_ready = (cyc % 2 == 0);
      check("cs_cd_valid", cd_valid, 1'b1);
      check("cs_cd_data", cd_data, beat_val(32'hD0D0_0005, cnt));
      check("cs_cd_last", cd_last, cnt == 7);
      if (cd_ready) cnt++;
      @(negedge clk);
    end
    check("cs_beats", cnt, 8);
    check("cs_ac_ready", ac_ready, 1'b1);
    cd_ready = 1;

    // ReadOnce, reset during beat 3
    send_ac(SnpReadOnce, 64'h0000_0000_0000_3000);
    lookup(64'h0000_0000_0000_3000, 1'b1, 1'b0, 1'b0, 32'hE0E0_0006);
    check("ro_cr_resp", cr_resp, 5'h19);
    @(negedge clk);
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("ro_beat3", cd_data, beat_val(32'hE0E0_0006, 3));
    rst_n = 1'b0;
    #1;
    check("rst_mid_cd_valid", cd_valid, 1'b0);
    check("rst_mid_cr_valid", cr_valid, 1'b0);
    check("rst_mid_upd_valid", upd_valid, 1'b0);
    check("rst_mid_lkp_req", lkp_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ac_ready", ac_ready, 1'b1);
    send_ac(SnpReadOnce, 64'h0000_0000_0000_4010);
    lookup(64'h0000_0000_0000_4000, 1'b1, 1'b0, 1'b0, 32'hF0F0_0007);
    check("ro2_cr_valid", cr_valid, 1'b1);
    check("ro2_cr_resp", cr_resp, 5'h19);
    @(negedge clk);
    burst(32'hF0F0_0007);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
